// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light sequencer and its receive-side monitor.
// This covers the light codes, the fault codes and the monitor state encoding.
package traffic_light_pkg;

  typedef logic [1:0] light_t;

  localparam light_t LIGHT_RED    = 2'b00;
  localparam light_t LIGHT_YELLOW = 2'b01;
  localparam light_t LIGHT_GREEN  = 2'b10;
  localparam light_t LIGHT_OFF    = 2'b11;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE  = 2'b00;
  localparam err_code_t ERR_JUMP  = 2'b01;
  localparam err_code_t ERR_STUCK = 2'b10;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } mon_state_t;

endpackage

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the sequencer's light code bus. It tracks the phase order and dwell,
// latches the first illegal-jump or stuck-phase fault, and grants go during legal green.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MAX_DWELL = 8,
  parameter int DWELL_W   = 4,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         light,
  input  logic               clr_err,
  output logic               go,
  output logic               err,
  output logic [1:0]         err_code,
  output logic [1:0]         phase,
  output logic [DWELL_W-1:0] dwell,
  output logic [CNT_W-1:0]   cycle_cnt
);

  mon_state_t         r_state, w_state_nxt;
  logic               r_go, w_go;
  logic               r_err, w_err;
  err_code_t          r_err_code, w_err_code;
  light_t             r_phase, w_phase;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic [CNT_W-1:0]   r_cnt, w_cnt;

  logic w_hold, w_adv, w_stuck, w_jump;

  assign w_hold  = (light == r_phase);
  assign w_adv   = (light == light_t'(r_phase + 2'd1));
  assign w_stuck = w_hold && (r_dwell == DWELL_W'(MAX_DWELL));
  assign w_jump  = !w_hold && !w_adv;

  // State register plus the registered outputs; reset is sampled on the clock edge only.
  // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= SYNC;
      r_go       <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_phase    <= LIGHT_RED;
      r_dwell    <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_go       <= w_go;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      r_phase    <= w_phase;
      r_dwell    <= w_dwell;
      r_cnt      <= w_cnt;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      SYNC:    if (light == LIGHT_RED) w_state_nxt = TRACK;
      TRACK:   if (w_stuck || w_jump)  w_state_nxt = FAULT;
      FAULT:   if (clr_err)            w_state_nxt = SYNC;
      default: w_state_nxt = SYNC;
    endcase
  end

  // Next values of the registered outputs. A fault freezes phase, dwell and the counter.
  always_comb begin
    w_go       = 1'b0;
    w_err      = r_err;
    w_err_code = r_err_code;
    w_phase    = r_phase;
    w_dwell    = r_dwell;
    w_cnt      = r_cnt;
    unique case (r_state)
      SYNC: begin
        w_dwell = '0;
        if (light == LIGHT_RED) begin
          w_phase = LIGHT_RED;
          w_dwell = DWELL_W'(1);
        end
      end
      TRACK: begin
        if (w_stuck) begin
          w_err      = 1'b1;
          w_err_code = ERR_STUCK;
        end else if (w_jump) begin
          w_err      = 1'b1;
          w_err_code = ERR_JUMP;
        end else if (w_hold) begin
          w_dwell = r_dwell + DWELL_W'(1);
          w_go    = (r_phase == LIGHT_GREEN);
        end else begin
          w_phase = light;
          w_dwell = DWELL_W'(1);
          w_go    = (light == LIGHT_GREEN);
          if (light == LIGHT_RED && r_cnt != {CNT_W{1'b1}})
            w_cnt = r_cnt + CNT_W'(1);
        end
      end
      FAULT: begin
        if (clr_err) begin
          w_err      = 1'b0;
          w_err_code = ERR_NONE;
          w_dwell    = '0;
        end
      end
      default: begin
        w_dwell = '0;
      end
    endcase
  end

  assign go        = r_go;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign phase     = r_phase;
  assign dwell     = r_dwell;
  assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor. A second instance with a 2-bit cycle counter
// exercises counter saturation. Both instances share the same stimulus.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] light = 2'b00;
  logic       clr_err = 1'b0;

  logic       go, err;
  logic [1:0] err_code, phase;
  logic [3:0] dwell;
  logic [7:0] cycle_cnt;

  logic       s_go, s_err;
  logic [1:0] s_err_code, s_phase;
  logic [3:0] s_dwell;
  logic [1:0] s_cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.MAX_DWELL(8), .DWELL_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .light(light), .clr_err(clr_err),
    .go(go), .err(err), .err_code(err_code), .phase(phase),
    .dwell(dwell), .cycle_cnt(cycle_cnt)
  );

  traffic_light_monitor #(.MAX_DWELL(8), .DWELL_W(4), .CNT_W(2)) u_dut_small (
    .clk(clk), .reset(reset), .light(light), .clr_err(clr_err),
    .go(s_go), .err(s_err), .err_code(s_err_code), .phase(s_phase),
    .dwell(s_dwell), .cycle_cnt(s_cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a code at the falling edge, then sample just after the next rising edge.
  task automatic step(input logic [1:0] l);
    @(negedge clk);
    light = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_go, input logic e_err,
                           input logic [1:0] e_code, input logic [1:0] e_phase,
                           input logic [3:0] e_dwell, input logic [7:0] e_cnt);
    check({tag, ".go"},       32'(go),        32'(e_go));
    check({tag, ".err"},      32'(err),       32'(e_err));
    check({tag, ".err_code"}, 32'(err_code),  32'(e_code));
    check({tag, ".phase"},    32'(phase),     32'(e_phase));
    check({tag, ".dwell"},    32'(dwell),     32'(e_dwell));
    check({tag, ".cnt"},      32'(cycle_cnt), 32'(e_cnt));
  endtask

  int exp_small [5] = '{1, 2, 3, 3, 3};

  initial begin
    // 1: reset then one legal lap
    repeat (2) @(posedge clk);
    #1;
    check_all("rst", 0, 0, 2'b00, 2'b00, 0, 0);
    reset = 1'b1;
    step(2'b00); check_all("t1_red",   0, 0, 2'b00, 2'b00, 1, 0);
    step(2'b01); check_all("t1_yel",   0, 0, 2'b00, 2'b01, 1, 0);
    step(2'b10); check_all("t1_grn",   1, 0, 2'b00, 2'b10, 1, 0);
    step(2'b11); check_all("t1_off",   0, 0, 2'b00, 2'b11, 1, 0);
    step(2'b00); check_all("t1_wrap",  0, 0, 2'b00, 2'b00, 1, 1);

    // 2: illegal jump red->green, then fault is sticky and first code wins
    step(2'b10); check_all("t2_jump",  0, 1, 2'b01, 2'b00, 1, 1);
    step(2'b11); check_all("t2_ill",   0, 1, 2'b01, 2'b00, 1, 1);
    step(2'b01); check_all("t2_leg",   0, 1, 2'b01, 2'b00, 1, 1);
    step(2'b10); check_all("t2_grn",   0, 1, 2'b01, 2'b00, 1, 1);

    // 4: clear, resync on red, counter preserved
    clr_err = 1'b1;
    step(2'b01); check_all("t4_clr",   0, 0, 2'b00, 2'b00, 0, 1);
    clr_err = 1'b0;
    step(2'b01); check_all("t4_ign1",  0, 0, 2'b00, 2'b00, 0, 1);
    step(2'b10); check_all("t4_ign2",  0, 0, 2'b00, 2'b00, 0, 1);
    step(2'b00); check_all("t4_sync",  0, 0, 2'b00, 2'b00, 1, 1);
    step(2'b01); check_all("t4_adv",   0, 0, 2'b00, 2'b01, 1, 1);

    // 3: hold yellow until the stuck fault (first yellow sample already taken)
    for (int k = 2; k <= 8; k++) begin
      step(2'b01);
      check("t3_dwell", 32'(dwell), 32'(k));
      check("t3_noerr", 32'(err), 32'd0);
    end
    step(2'b01); check_all("t3_stuck", 0, 1, 2'b10, 2'b01, 8, 1);

    // clr_err outside FAULT has no effect
    clr_err = 1'b1;
    step(2'b00); check_all("t3_clr",   0, 0, 2'b00, 2'b01, 0, 1);
    step(2'b00); check_all("t3_sync",  0, 0, 2'b00, 2'b00, 1, 1);
    step(2'b01); check_all("t3_clrtr", 0, 0, 2'b00, 2'b01, 1, 1);
    clr_err = 1'b0;

    // 5: reset in green; a reset glitch between edges must not act
    step(2'b10); check_all("t5_grn",   1, 0, 2'b00, 2'b10, 1, 1);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_all("t5_glitch", 1, 0, 2'b00, 2'b10, 1, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("t5_rst", 0, 0, 2'b00, 2'b00, 0, 0);
    reset = 1'b1;

    // 6: five laps; the 2-bit counter saturates at 3
    step(2'b00);
    for (int w = 0; w < 5; w++) begin
      step(2'b01);
      step(2'b10);
      check("t6_go", 32'(s_go), 32'd1);
      step(2'b11);
      step(2'b00);
      check("t6_cnt_small", 32'(s_cycle_cnt), 32'(exp_small[w]));
      check("t6_err_small", 32'(s_err), 32'd0);
    end
    check("t6_cnt_wide", 32'(cycle_cnt), 32'd5);
    check("t6_err_wide", 32'(err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
